// File: rtl/mod_addsub_pipe.sv
// Purpose: pipelined (a+b) mod p / (a-b) mod p with one conditional correction step.
// Latency: 2 cycles from accept to out_valid when not stalled; 1 op/cycle sustained.
// Backpressure: valid/ready. in_ready is combinational from out_ready, so there is no bubble.
module mod_addsub_pipe #(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] MODULUS = 64'hFFFF_FFFF_0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out
);

    // Modulus widened by one bit so it can be compared against the raw stage-1 value.
    localparam logic [WIDTH:0] P_EXT = {1'b0, MODULUS};

    // Stage 1: raw sum/difference plus operation flag.
    logic             s1_v;
    logic             s1_sub;
    logic [WIDTH:0]   s1_t;

    // Stage 2: reduced result that drives the output.
    logic             s2_v;
    logic [WIDTH-1:0] s2_dat;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH:0]   t_in;
    logic [WIDTH-1:0] t_minus_p;
    logic [WIDTH-1:0] t_plus_p;
    logic [WIDTH-1:0] red_dat;

    // Each stage may move when it is empty or when the stage after it is moving.
    always_comb begin
        s2_adv   = !s2_v || out_ready;
        s1_adv   = !s1_v || s2_adv;
        in_ready = s1_adv;
    end

    // Raw add or subtract at WIDTH+1 bits; for subtract the top bit is the borrow.
    always_comb begin
        t_in = '0;
        if (sub_in) begin
            t_in = {1'b0, a_in} - {1'b0, b_in};
        end else begin
            t_in = {1'b0, a_in} + {1'b0, b_in};
        end
    end

    // Single correction step. Only the low WIDTH bits of t-p and t+p survive,
    // so both are computed at WIDTH bits directly.
    always_comb begin
        t_minus_p = s1_t[WIDTH-1:0] - MODULUS;
        t_plus_p  = s1_t[WIDTH-1:0] + MODULUS;
        red_dat   = s1_t[WIDTH-1:0];
        if (s1_sub) begin
            if (s1_t[WIDTH]) begin
                red_dat = t_plus_p;
            end
        end else begin
            if (s1_t >= P_EXT) begin
                red_dat = t_minus_p;
            end
        end
    end

    // Pipeline registers. A stage whose advance is low holds its data and valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_sub <= 1'b0;
            s1_t   <= '0;
            s2_v   <= 1'b0;
            s2_dat <= '0;
        end else begin
            if (s2_adv) begin
                s2_v   <= s1_v;
                s2_dat <= red_dat;
            end
            if (s1_adv) begin
                s1_v   <= in_valid;
                s1_sub <= sub_in;
                s1_t   <= t_in;
            end
        end
    end

    assign out_valid = s2_v;
    assign sum_out   = s2_dat;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Purpose: bench for mod_addsub_pipe; expected results are queued at accept and compared at output.
// Latency: expects a 2-cycle accept-to-consume latency whenever the output is not stalled.
// Backpressure: exercises full-pipe stall, random out_ready and reset with results in flight.
module tb_mod_addsub_pipe;

    localparam int          W = 64;
    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          sub_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum_out;

    mod_addsub_pipe #(.WIDTH(W), .MODULUS(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] val;
        int          acc_cyc;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          check_lat = 1'b1;
    logic [63:0] drv_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Independent reference: wide arithmetic followed by a true modulo.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [127:0] x;
        if (s) x = ({64'd0, a} + {64'd0, P} - {64'd0, b}) % {64'd0, P};
        else   x = ({64'd0, a} + {64'd0, b}) % {64'd0, P};
        return x[63:0];
    endfunction

    function automatic logic [63:0] rand_legal();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (r >= P) r = r - P;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling mid-cycle what the coming edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("out_unexpected", {63'd0, out_valid}, 64'd0);
                end else begin
                    sb_entry_t e;
                    e = sb_q.pop_front();
                    check("result", sum_out, e.val);
                    if (check_lat) check("latency", 64'(cyc + 1 - e.acc_cyc), 64'd2);
                end
            end
            if (in_valid && in_ready) sb_q.push_back('{drv_exp, cyc + 1});
        end
    end

    // Present one op and hold it until accepted; leaves inputs idle only when the next op is not chained.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [63:0] e);
        bit acc;
        acc      = 1'b0;
        a_in     = a;
        b_in     = b;
        sub_in   = s;
        drv_exp  = e;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("accept_timeout", {63'd0, acc}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("drain_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [63:0] held;
    bit          rnd_done;

    initial begin
        rst = 1'b1; in_valid = 1'b1; a_in = 64'd5; b_in = 64'd7; sub_in = 1'b0; out_ready = 1'b1;
        tick(3);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum_out", sum_out, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_no_output", {63'd0, out_valid}, 64'd0);
        end

        // Directed add and subtract cases, including wrap and borrow.
        send(P - 64'd1, 64'd1,         1'b0, 64'd0);
        send(64'd5,     64'd7,         1'b0, 64'd12);
        send(P - 64'd1, P - 64'd1,     1'b0, P - 64'd2);
        send(64'd3,     64'd5,         1'b1, P - 64'd2);
        send(64'd9,     64'd9,         1'b1, 64'd0);
        send(64'd0,     P - 64'd1,     1'b1, 64'd1);
        drain();

        // Back-to-back random stream at full throughput.
        for (int i = 0; i < 100; i++) begin
            logic [63:0] a, b;
            logic s;
            a = rand_legal(); b = rand_legal(); s = 1'($urandom_range(0, 1));
            send(a, b, s, model(a, b, s));
        end
        drain();

        // Fill both stages and stall the output.
        check_lat = 1'b0;
        out_ready = 1'b0;
        send(64'd100, 64'd23, 1'b0, 64'd123);
        send(64'd10,  64'd11, 1'b1, P - 64'd1);
        held = sum_out;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_sum_stable", sum_out, held);
            tick(1);
        end
        check("stall_head", sum_out, 64'd123);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_1st_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("release_2nd_valid", {63'd0, out_valid}, 64'd1);
        check("release_2nd_data", sum_out, P - 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Random output backpressure against the scoreboard.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [63:0] a, b;
                    logic s;
                    a = rand_legal(); b = rand_legal(); s = 1'($urandom_range(0, 1));
                    send(a, b, s, model(a, b, s));
                    if ($urandom_range(0, 3) == 0) tick(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset while both stages hold results.
        out_ready = 1'b0;
        send(64'd1, 64'd2, 1'b0, 64'd3);
        send(64'd4, 64'd5, 1'b0, 64'd9);
        check("pre_rst_full", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        check_lat = 1'b1;
        send(64'd20, 64'd30, 1'b1, P - 64'd10);
        drain();
        tick(3);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: reached cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
